// File: rtl/ok_trigger_out_fifo_if.sv
// Endpoint/host signal bundle for ok_trigger_out_fifo.
// The slave modport is the endpoint itself; the master modport is the user/host side.
interface ok_trigger_out_fifo_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] ep_trigger;
    logic             ep_commit;
    logic             ep_pending;
    logic             ep_overflow;
    logic [7:0]       host_addr;
    logic             host_update;
    logic             host_status_ack;
    logic [31:0]      host_data;

    modport slave (
        input  ep_trigger, ep_commit, host_addr, host_update, host_status_ack,
        output ep_pending, ep_overflow, host_data
    );

    modport master (
        output ep_trigger, ep_commit, host_addr, host_update, host_status_ack,
        input  ep_pending, ep_overflow, host_data
    );
endinterface

// File: rtl/ok_trigger_out_fifo.sv
// Trigger-out endpoint: edge-detects a trigger vector, coalesces edges, queues committed
// snapshots in a small FIFO popped by the host. Optional macro: TRIGOUT_AUTOCOMMIT_EN.
module ok_trigger_out_fifo #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [7:0]       BASE_ADDR = 8'h60,
    parameter logic [WIDTH-1:0] RISE_MASK = '1,
    parameter logic [WIDTH-1:0] FALL_MASK = '0
) (
    input logic                   ep_clk,
    input logic                   ep_reset_n,
    ok_trigger_out_fifo_if.slave  bus
);
    localparam int unsigned WORDS = (WIDTH + 31) / 32;
    localparam int unsigned HW    = WORDS * 32;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [WIDTH-1:0] trig_p1, accum, accum_nxt, hold, hold_nxt, edge_v, snap;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, tail_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             overflow, overflow_nxt, pending;
    logic             empty, full, pop, push, merge, auto_load;
    logic [HW-1:0]    hold_ext;
    logic [31:0]      read_data;

    assign bus.ep_pending  = pending;
    assign bus.ep_overflow = overflow;
    assign bus.host_data   = read_data;

    // Next-state: pop sees the pre-cycle FIFO, so a full FIFO popped this cycle can still accept a push.
    always_comb begin
        edge_v   = (RISE_MASK & bus.ep_trigger & ~trig_p1) | (FALL_MASK & ~bus.ep_trigger & trig_p1);
        snap     = accum | edge_v;
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        pop      = bus.host_update && !empty;
        push     = bus.ep_commit && (!full || pop);
        merge    = bus.ep_commit && full && !pop;
        tail_ptr = wr_ptr - PW'(1);
`ifdef TRIGOUT_AUTOCOMMIT_EN
        auto_load = bus.host_update && empty && !bus.ep_commit;
`else
        auto_load = 1'b0;
`endif
        hold_nxt = hold;
        if (pop) begin
            hold_nxt = mem[rd_ptr];
        end else if (auto_load) begin
            hold_nxt = snap;
        end else if (bus.host_update) begin
            hold_nxt = '0;
        end
        accum_nxt  = (bus.ep_commit || auto_load) ? '0 : snap;
        wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;
        count_nxt  = count + CW'(push) - CW'(pop);
        if (merge) begin
            overflow_nxt = 1'b1;
        end else if (bus.host_status_ack) begin
            overflow_nxt = 1'b0;
        end else begin
            overflow_nxt = overflow;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge ep_clk or negedge ep_reset_n) begin
        if (!ep_reset_n) begin
            trig_p1  <= '0;
            accum    <= '0;
            hold     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            pending  <= 1'b0;
        end else begin
            trig_p1  <= bus.ep_trigger;
            accum    <= accum_nxt;
            hold     <= hold_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            pending  <= (count_nxt != '0);
        end
    end

    // Snapshot storage; a commit into a full FIFO merges into the newest entry so no edge is lost.
    always_ff @(posedge ep_clk) begin
        if (push) begin
            mem[wr_ptr] <= snap;
        end else if (merge) begin
            mem[tail_ptr] <= mem[tail_ptr] | snap;
        end
    end

    // OR-bus read decode, zero latency from host_addr.
    always_comb begin
        read_data = '0;
        hold_ext  = HW'(hold);
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (bus.host_addr == BASE_ADDR + 8'(k)) begin
                read_data = hold_ext[k*32 +: 32];
            end
        end
        if (bus.host_addr == BASE_ADDR + 8'(WORDS)) begin
            read_data = {23'b0, 5'(count), 2'b0, overflow, pending};
        end
    end
endmodule
